// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush and load-use stall,
// decoded combinationally from a RUN/MEM_WAIT/ERROR FSM, with a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IdRs,
  input  logic [4:0]  IdRt,
  input  logic        IdUsesRt,
  input  logic        ExMemRead,
  input  logic [4:0]  ExRegd,
  input  logic        BranchTaken,
  input  logic        MemReq,
  input  logic        MemReady,
  output logic        PcWrite,
  output logic        IfIdWrite,
  output logic        IdExWrite,
  output logic        ExMemWrite,
  output logic        IfIdFlush,
  output logic        IdExFlush,
  output logic        MemWbBubble,
  output logic        MemTimeout,
  output logic [15:0] StallCycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_next;
  logic [15:0] stall_cnt;
  logic        freeze;
  logic        load_use;

  assign load_use = ExMemRead && (ExRegd != 5'd0) &&
                    ((ExRegd == IdRs) || (IdUsesRt && (ExRegd == IdRt)));

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    freeze     = 1'b0;
    case (state)
      RUN: begin
        // A request that completes in the same cycle never leaves RUN.
        if (MemReq && !MemReady) begin
          freeze     = 1'b1;
          state_next = MEM_WAIT;
          wait_next  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (MemReady) begin
          state_next = RUN;
          wait_next  = 8'd0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt == TIMEOUT_CNT) begin
            state_next = ERROR;
          end else begin
            wait_next = wait_cnt + 8'd1;
          end
        end
      end
      ERROR: begin
        freeze = 1'b1;
      end
      default: begin
        state_next = RUN;
        wait_next  = 8'd0;
      end
    endcase
    if (reset) begin
      freeze = 1'b1;
    end
  end

  always_comb begin
    PcWrite     = 1'b1;
    IfIdWrite   = 1'b1;
    IdExWrite   = 1'b1;
    ExMemWrite  = 1'b1;
    IfIdFlush   = 1'b0;
    IdExFlush   = 1'b0;
    MemWbBubble = 1'b0;
    if (freeze) begin
      PcWrite     = 1'b0;
      IfIdWrite   = 1'b0;
      IdExWrite   = 1'b0;
      ExMemWrite  = 1'b0;
      MemWbBubble = 1'b1;
    end else if (BranchTaken) begin
      IfIdFlush = 1'b1;
      IdExFlush = 1'b1;
    end else if (load_use) begin
      PcWrite   = 1'b0;
      IfIdWrite = 1'b0;
      IdExFlush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= 16'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (!PcWrite && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign MemTimeout  = (state == ERROR);
  assign StallCycles = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic against a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;
  // Output vector order: PcWrite IfIdWrite IdExWrite ExMemWrite IfIdFlush IdExFlush MemWbBubble
  localparam logic [6:0] FREEZE = 7'b0000001;
  localparam logic [6:0] FLUSH  = 7'b1111110;
  localparam logic [6:0] STALL  = 7'b0011010;
  localparam logic [6:0] GO     = 7'b1111000;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IdRs, IdRt, ExRegd;
  logic        IdUsesRt, ExMemRead, BranchTaken, MemReq, MemReady;
  logic        PcWrite, IfIdWrite, IdExWrite, ExMemWrite;
  logic        IfIdFlush, IdExFlush, MemWbBubble, MemTimeout;
  logic [15:0] StallCycles;
  logic [6:0]  outs;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: consecutive cycles a memory access has been outstanding, dead flag, stall count.
  int m_pend   = 0;
  bit m_dead   = 1'b0;
  int m_stalls = 0;

  pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .IdRs(IdRs), .IdRt(IdRt), .IdUsesRt(IdUsesRt),
    .ExMemRead(ExMemRead), .ExRegd(ExRegd), .BranchTaken(BranchTaken),
    .MemReq(MemReq), .MemReady(MemReady),
    .PcWrite(PcWrite), .IfIdWrite(IfIdWrite), .IdExWrite(IdExWrite), .ExMemWrite(ExMemWrite),
    .IfIdFlush(IfIdFlush), .IdExFlush(IdExFlush), .MemWbBubble(MemWbBubble),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles)
  );

  assign outs = {PcWrite, IfIdWrite, IdExWrite, ExMemWrite, IfIdFlush, IdExFlush, MemWbBubble};

  always #5 clk = ~clk;

  function automatic logic [6:0] model_out();
    bit frozen;
    frozen = reset || m_dead || (!MemReady && ((m_pend > 0) || MemReq));
    if (frozen) return FREEZE;
    if (BranchTaken) return FLUSH;
    if (ExMemRead && (ExRegd != 5'd0) &&
        ((ExRegd == IdRs) || (IdUsesRt && (ExRegd == IdRt)))) return STALL;
    return GO;
  endfunction

  task automatic tick();
    logic [6:0] o;
    @(posedge clk);
    o = model_out();
    if (reset) begin
      m_pend = 0; m_dead = 1'b0; m_stalls = 0;
    end else begin
      if (!o[6] && (m_stalls < 65535)) m_stalls++;
      if (!m_dead) begin
        if (MemReady) m_pend = 0;
        else if ((m_pend > 0) || MemReq) m_pend++;
        // The request cycle plus TO wait cycles is the last tolerated stall.
        if (m_pend > TO + 1 - 1 + 1 - 1) begin
          if (m_pend > TO) begin m_dead = 1'b1; m_pend = 0; end
        end
      end
    end
    #1;
  endtask

  task automatic set_idle();
    IdRs = 5'd0; IdRt = 5'd0; IdUsesRt = 1'b0; ExMemRead = 1'b0; ExRegd = 5'd0;
    BranchTaken = 1'b0; MemReq = 1'b0; MemReady = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    MemReq = 1'b1; BranchTaken = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== FREEZE) begin
      n_errors++; $display("FAIL reset_outs: got %b want %b", outs, FREEZE);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (outs !== FREEZE || StallCycles !== 16'd0 || MemTimeout !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hold: outs %b want %b, stalls %0d want 0, timeout %b want 0",
               outs, FREEZE, StallCycles, MemTimeout);
    end
    tick();
    reset = 1'b0;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (outs !== GO || StallCycles !== 16'd0) begin
      n_errors++; $display("FAIL reset_release: outs %b want %b, stalls %0d want 0", outs, GO, StallCycles);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ExMemRead = 1'b1; ExRegd = 5'd8; IdRs = 5'd8;
    @(negedge clk);
    n_checks++;
    if (outs !== STALL || StallCycles !== 16'd0) begin
      n_errors++; $display("FAIL load_use_rs: outs %b want %b, stalls %0d want 0", outs, STALL, StallCycles);
    end
    tick();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (StallCycles !== 16'd1) begin
      n_errors++; $display("FAIL load_use_count: got %0d want 1", StallCycles);
    end
    ExMemRead = 1'b1; ExRegd = 5'd0; IdRs = 5'd0;
    @(negedge clk);
    n_checks++;
    if (outs !== GO) begin
      n_errors++; $display("FAIL load_use_r0: got %b want %b", outs, GO);
    end
    tick();
    ExRegd = 5'd5; IdRs = 5'd1; IdRt = 5'd5; IdUsesRt = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs !== GO || StallCycles !== 16'd1) begin
      n_errors++; $display("FAIL load_use_rt_unused: outs %b want %b, stalls %0d want 1", outs, GO, StallCycles);
    end
    tick();
    IdUsesRt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== STALL) begin
      n_errors++; $display("FAIL load_use_rt: got %b want %b", outs, STALL);
    end
    tick();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (StallCycles !== 16'd2) begin
      n_errors++; $display("FAIL load_use_rt_count: got %0d want 2", StallCycles);
    end
  endtask

  task automatic test_branch();
    do_reset();
    BranchTaken = 1'b1; ExMemRead = 1'b1; ExRegd = 5'd8; IdRs = 5'd8;
    @(negedge clk);
    n_checks++;
    if (outs !== FLUSH) begin
      n_errors++; $display("FAIL branch_hazard: got %b want %b", outs, FLUSH);
    end
    tick();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (StallCycles !== 16'd0) begin
      n_errors++; $display("FAIL branch_count: got %0d want 0", StallCycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    MemReq = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs !== FREEZE) begin
        n_errors++; $display("FAIL mem_wait_freeze%0d: got %b want %b", i, outs, FREEZE);
      end
      tick();
    end
    MemReady = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== GO) begin
      n_errors++; $display("FAIL mem_wait_release: got %b want %b", outs, GO);
    end
    tick();
    MemReq = 1'b0; MemReady = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs !== GO || StallCycles !== 16'd3) begin
      n_errors++; $display("FAIL mem_wait_after: outs %b want %b, stalls %0d want 3", outs, GO, StallCycles);
    end
    tick();
    MemReq = 1'b1; MemReady = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== GO) begin
      n_errors++; $display("FAIL single_cycle_access: got %b want %b", outs, GO);
    end
    tick();
    MemReq = 1'b0; MemReady = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs !== GO || StallCycles !== 16'd3) begin
      n_errors++; $display("FAIL single_cycle_after: outs %b want %b, stalls %0d want 3", outs, GO, StallCycles);
    end
  endtask

  task automatic test_timeout();
    logic exp_to;
    do_reset();
    MemReq = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_to = (i >= TO + 1);
      @(negedge clk);
      n_checks++;
      if (outs !== FREEZE || MemTimeout !== exp_to) begin
        n_errors++;
        $display("FAIL timeout_cycle%0d: outs %b want %b, timeout %b want %b", i, outs, FREEZE, MemTimeout, exp_to);
      end
      tick();
    end
    MemReq = 1'b0; MemReady = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== FREEZE || MemTimeout !== 1'b1) begin
      n_errors++; $display("FAIL timeout_sticky: outs %b want %b, timeout %b want 1", outs, FREEZE, MemTimeout);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (outs !== GO || MemTimeout !== 1'b0 || StallCycles !== 16'd0) begin
      n_errors++;
      $display("FAIL timeout_reset: outs %b want %b, timeout %b want 0, stalls %0d want 0",
               outs, GO, MemTimeout, StallCycles);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    MemReq = 1'b1; MemReady = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (dut.wait_cnt !== 8'd2 || outs !== FREEZE) begin
      n_errors++; $display("FAIL mid_wait_setup: waitcnt %0d want 2, outs %b want %b", dut.wait_cnt, outs, FREEZE);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (outs !== GO || StallCycles !== 16'd0 || dut.wait_cnt !== 8'd0) begin
      n_errors++;
      $display("FAIL mid_wait_reset: outs %b want %b, stalls %0d want 0, waitcnt %0d want 0",
               outs, GO, StallCycles, dut.wait_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] exp;
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 39) == 0);
      IdRs        = 5'($urandom_range(0, 3));
      IdRt        = 5'($urandom_range(0, 3));
      ExRegd      = 5'($urandom_range(0, 3));
      IdUsesRt    = 1'($urandom_range(0, 1));
      ExMemRead   = 1'($urandom_range(0, 1));
      BranchTaken = ($urandom_range(0, 4) == 0);
      MemReq      = ($urandom_range(0, 9) < 3);
      MemReady    = 1'($urandom_range(0, 1));
      exp = model_out();
      @(negedge clk);
      n_checks++;
      if (outs !== exp || StallCycles !== 16'(m_stalls) || MemTimeout !== m_dead) begin
        n_errors++;
        $display("FAIL random%0d: outs %b want %b, stalls %0d want %0d, timeout %b want %b",
                 i, outs, exp, StallCycles, m_stalls, MemTimeout, m_dead);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    ExMemRead = 1'b1; ExRegd = 5'd3; IdRs = 5'd3;
    for (int i = 0; i < 65540; i++) tick();
    @(negedge clk);
    n_checks++;
    if (StallCycles !== 16'hFFFF || StallCycles !== 16'(m_stalls)) begin
      n_errors++; $display("FAIL saturate: got %h want ffff", StallCycles);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (StallCycles !== 16'hFFFF || outs !== STALL) begin
      n_errors++; $display("FAIL saturate_hold: stalls %h want ffff, outs %b want %b", StallCycles, outs, STALL);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of MEM_WAIT cycles before the error state (range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports IdRs and IdRt, input, 5 bits each: source registers of the instruction in ID.
REQ-005 SHALL have port IdUsesRt, input, 1 bit: the ID instruction reads Rt.
REQ-006 SHALL have ports ExMemRead (input, 1 bit) and ExRegd (input, 5 bits): the EX instruction is a load, and its destination register.
REQ-007 SHALL have port BranchTaken, input, 1 bit: a branch or jump resolved taken in EX.
REQ-008 SHALL have ports MemReq and MemReady, input, 1 bit each: the MEM-stage instruction accesses data memory, and the memory completes this cycle.
REQ-009 SHALL have outputs PcWrite, IfIdWrite, IdExWrite and ExMemWrite, 1 bit each: pipeline register enables.
REQ-010 SHALL have outputs IfIdFlush, IdExFlush and MemWbBubble, 1 bit each: clear the named register or insert a bubble.
REQ-011 SHALL have output MemTimeout, 1 bit: sticky memory-timeout error.
REQ-012 SHALL have output StallCycles, 16 bits: saturating count of cycles with PcWrite=0.

Function
REQ-013 SHALL implement an FSM with states RUN, MEM_WAIT and ERROR, plus an 8-bit WaitCnt register.
REQ-014 SHALL decode outputs combinationally from the current state and inputs, and SHALL NOT add any cycle of latency.
REQ-015 SHALL define the freeze set as PcWrite=IfIdWrite=IdExWrite=ExMemWrite=0, MemWbBubble=1, IfIdFlush=IdExFlush=0.
REQ-016 SHALL, in RUN with MemReq=1 and MemReady=0, drive the freeze set, move to MEM_WAIT and set WaitCnt to 1.
REQ-017 SHALL, in MEM_WAIT with MemReady=0, drive the freeze set and increment WaitCnt; when WaitCnt==TIMEOUT it SHALL move to ERROR instead.
REQ-018 SHALL, in MEM_WAIT with MemReady=1, release the freeze that cycle (normal RUN decode per REQ-020..REQ-022), clear WaitCnt and return to RUN.
REQ-019 SHALL, in ERROR, drive the freeze set with MemTimeout=1; ERROR SHALL be left only by reset.
REQ-020 SHALL, in RUN when not frozen and BranchTaken=1, drive IfIdFlush=1, IdExFlush=1, PcWrite=1 and all other enables 1; any load-use stall is ignored.
REQ-021 SHALL detect a load-use hazard when ExMemRead=1, ExRegd!=0, and (ExRegd==IdRs or (IdUsesRt=1 and ExRegd==IdRt)).
REQ-022 SHALL, on a load-use hazard with no freeze and no branch, drive PcWrite=0, IfIdWrite=0, IdExFlush=1, with IdExWrite=ExMemWrite=1 and MemWbBubble=0.
REQ-023 SHALL otherwise drive all enables 1 and all flush/bubble outputs 0.
REQ-024 SHALL apply priority memory freeze > branch flush > load-use stall.
REQ-025 SHALL increment StallCycles on every non-reset cycle with PcWrite=0, saturating at 16'hFFFF.
REQ-026 SHALL treat simultaneous MemReq=1 and MemReady=1 in RUN as a single-cycle access: no freeze, and the state stays RUN.

Reset
REQ-027 SHALL, on a clock edge with reset=1, set state=RUN, WaitCnt=0, StallCycles=0 and MemTimeout=0, including when the block is in MEM_WAIT or ERROR.
REQ-028 SHALL, while reset=1, drive the freeze set on the outputs and SHALL NOT count stalls.

Verification
REQ-029 SHALL cover load-use: ExMemRead=1, ExRegd=8, IdRs=8 -> PcWrite=0, IfIdWrite=0, IdExFlush=1, StallCycles 0->1; the same with ExRegd=0 -> no stall.
REQ-030 SHALL cover branch with hazard: BranchTaken=1 together with the REQ-029 load-use -> IfIdFlush=1, IdExFlush=1, PcWrite=1, StallCycles unchanged.
REQ-031 SHALL cover a memory wait: MemReq=1, MemReady=0 for 3 cycles, then 1 -> freeze set for 3 cycles, release on the 4th, state RUN, StallCycles=3.
REQ-032 SHALL cover timeout: TIMEOUT=4, MemReq=1, MemReady held 0 -> ERROR after 4 wait cycles, MemTimeout=1 held; reset -> MemTimeout=0, RUN.
REQ-033 SHALL cover reset mid-wait: reset pulsed in MEM_WAIT with WaitCnt=2 -> next cycle RUN, WaitCnt=0, StallCycles=0.
REQ-034 SHALL cover saturation: force 65536+ stall cycles -> StallCycles holds 16'hFFFF.
